// File: rtl/csr_machine_file.sv
// Machine-mode CSR file: registered CSR access port, 64-bit cycle/instret
// counters, trap/mret status updates and interrupt-pending generation.
module csr_machine_file #(
    parameter int unsigned       XLEN          = 32,
    parameter logic [31:0]       MISA_VAL      = 32'h4000_0100,
    parameter logic [31:0]       MVENDORID_VAL = 32'h0,
    parameter logic [31:0]       MARCHID_VAL   = 32'h0,
    parameter logic [31:0]       MIMPID_VAL    = 32'h0,
    parameter logic [31:0]       HART_ID       = 32'h0,
    parameter logic [XLEN-1:0]   MTVEC_RST     = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            csr_req_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [1:0]      csr_op_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_ack_o,
    output logic            csr_illegal_o,
    input  logic            instret_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            mret_i,
    input  logic            irq_ext_i,
    input  logic            irq_timer_i,
    input  logic            irq_sw_i,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_global_o,
    output logic            irq_pending_o
);

    localparam logic [11:0] A_MSTATUS    = 12'h300;
    localparam logic [11:0] A_MISA       = 12'h301;
    localparam logic [11:0] A_MIE        = 12'h304;
    localparam logic [11:0] A_MTVEC      = 12'h305;
    localparam logic [11:0] A_MCOUNTEREN = 12'h306;
    localparam logic [11:0] A_MSCRATCH   = 12'h340;
    localparam logic [11:0] A_MEPC       = 12'h341;
    localparam logic [11:0] A_MCAUSE     = 12'h342;
    localparam logic [11:0] A_MIP        = 12'h344;
    localparam logic [11:0] A_MCYCLE     = 12'hB00;
    localparam logic [11:0] A_MINSTRET   = 12'hB02;
    localparam logic [11:0] A_MCYCLEH    = 12'hB80;
    localparam logic [11:0] A_MINSTRETH  = 12'hB82;
    localparam logic [11:0] A_MVENDORID  = 12'hF11;
    localparam logic [11:0] A_MARCHID    = 12'hF12;
    localparam logic [11:0] A_MIMPID     = 12'hF13;
    localparam logic [11:0] A_MHARTID    = 12'hF14;

    localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(32'h888);
    localparam logic [XLEN-1:0] ALIGN4   = ~XLEN'(3);
    localparam bit              HAS_HI   = (XLEN == 32);

    logic            st_mie;
    logic            st_mpie;
    logic [XLEN-1:0] mie_r;
    logic [XLEN-1:0] mip_r;
    logic [XLEN-1:0] mtvec_r;
    logic [XLEN-1:0] mepc_r;
    logic [XLEN-1:0] mcause_r;
    logic [XLEN-1:0] mscratch_r;
    logic [2:0]      mcounteren_r;
    logic [63:0]     mcycle;
    logic [63:0]     minstret;

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] mip_next;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] wmask;
    logic [XLEN-1:0] wval;
    logic            hit;
    logic            ro;
    logic            illegal;
    logic            wr;

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = st_mpie;
        mstatus_val[3]     = st_mie;
        mip_next           = '0;
        mip_next[11]       = irq_ext_i;
        mip_next[7]        = irq_timer_i;
        mip_next[3]        = irq_sw_i;
    end

    always_comb begin
        rd_val = '0;
        wmask  = '0;
        hit    = 1'b1;
        ro     = (csr_addr_i[11:10] == 2'b11);
        case (csr_addr_i)
            A_MSTATUS: begin
                rd_val   = mstatus_val;
                wmask[3] = 1'b1;
                wmask[7] = 1'b1;
            end
            A_MISA:      rd_val = XLEN'(MISA_VAL);
            A_MIE: begin
                rd_val = mie_r;
                wmask  = IRQ_MASK;
            end
            A_MTVEC: begin
                rd_val = mtvec_r;
                wmask  = ALIGN4;
            end
            A_MCOUNTEREN: begin
                rd_val = XLEN'(mcounteren_r);
                wmask  = XLEN'(3'b111);
            end
            A_MSCRATCH: begin
                rd_val = mscratch_r;
                wmask  = '1;
            end
            A_MEPC: begin
                rd_val = mepc_r;
                wmask  = ALIGN4;
            end
            A_MCAUSE: begin
                rd_val = mcause_r;
                wmask  = '1;
            end
            A_MIP: begin
                rd_val = mip_r;
                ro     = 1'b1;
            end
            A_MCYCLE: begin
                rd_val = mcycle[XLEN-1:0];
                wmask  = '1;
            end
            A_MINSTRET: begin
                rd_val = minstret[XLEN-1:0];
                wmask  = '1;
            end
            A_MCYCLEH: begin
                hit    = HAS_HI;
                rd_val = HAS_HI ? XLEN'(mcycle[63:32]) : '0;
                wmask  = '1;
            end
            A_MINSTRETH: begin
                hit    = HAS_HI;
                rd_val = HAS_HI ? XLEN'(minstret[63:32]) : '0;
                wmask  = '1;
            end
            A_MVENDORID: rd_val = XLEN'(MVENDORID_VAL);
            A_MARCHID:   rd_val = XLEN'(MARCHID_VAL);
            A_MIMPID:    rd_val = XLEN'(MIMPID_VAL);
            A_MHARTID:   rd_val = XLEN'(HART_ID);
            default:     hit = 1'b0;
        endcase
    end

    always_comb begin
        wval = rd_val;
        case (csr_op_i)
            2'b01:   wval = csr_wdata_i;
            2'b10:   wval = rd_val | csr_wdata_i;
            2'b11:   wval = rd_val & ~csr_wdata_i;
            default: wval = rd_val;
        endcase
        wval = wval & wmask;
    end

    assign illegal = ~hit | (ro & (csr_op_i != 2'b00));
    // Trap and mret own the status registers this cycle; the write is dropped.
    assign wr = csr_req_i & ~illegal & (csr_op_i != 2'b00)
              & ~trap_i & ~mret_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csr_ack_o     <= 1'b0;
            csr_illegal_o <= 1'b0;
            csr_rdata_o   <= '0;
            st_mie        <= 1'b0;
            st_mpie       <= 1'b0;
            mie_r         <= '0;
            mip_r         <= '0;
            mtvec_r       <= MTVEC_RST & ALIGN4;
            mepc_r        <= '0;
            mcause_r      <= '0;
            mscratch_r    <= '0;
            mcounteren_r  <= '0;
        end else begin
            csr_ack_o     <= csr_req_i;
            csr_illegal_o <= csr_req_i & illegal;
            csr_rdata_o   <= (csr_req_i & ~illegal) ? rd_val : '0;
            mip_r         <= mip_next;
            if (trap_i) begin
                mepc_r   <= trap_pc_i & ALIGN4;
                mcause_r <= trap_cause_i;
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end else if (mret_i) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (wr) begin
                case (csr_addr_i)
                    A_MSTATUS: begin
                        st_mie  <= wval[3];
                        st_mpie <= wval[7];
                    end
                    A_MIE:        mie_r        <= wval;
                    A_MTVEC:      mtvec_r      <= wval;
                    A_MCOUNTEREN: mcounteren_r <= wval[2:0];
                    A_MSCRATCH:   mscratch_r   <= wval;
                    A_MEPC:       mepc_r       <= wval;
                    A_MCAUSE:     mcause_r     <= wval;
                    default:      ;
                endcase
            end
        end
    end

    // A write to either half replaces it and skips that cycle's increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (wr && csr_addr_i == A_MCYCLE)
                mcycle[XLEN-1:0] <= wval;
            else if (wr && csr_addr_i == A_MCYCLEH)
                mcycle[63:32] <= wval[31:0];
            else
                mcycle <= mcycle + 64'd1;

            if (wr && csr_addr_i == A_MINSTRET)
                minstret[XLEN-1:0] <= wval;
            else if (wr && csr_addr_i == A_MINSTRETH)
                minstret[63:32] <= wval[31:0];
            else if (instret_i)
                minstret <= minstret + 64'd1;
        end
    end

    assign mtvec_o       = mtvec_r;
    assign mepc_o        = mepc_r;
    assign mie_global_o  = st_mie;
    assign irq_pending_o = st_mie & |(mip_r & mie_r);

endmodule
